// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order MIPS pipeline: per-stage enables and bubbles,
// load-use stalls, redirect squashing, ID-stage forwarding selects and perf counters.
module pipe_hazard_ctrl #(
   parameter int STAGES     = 5,
   parameter int REG_ADDR_W = 5,
   parameter int BR_STAGE   = 2,
   parameter int ALU_AVAIL  = 2,
   parameter int LOAD_AVAIL = 4,
   parameter int CNT_W      = 32,
   localparam int SEL_W     = $clog2(STAGES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic [REG_ADDR_W-1:0] id_dst,
   input  logic                  redirect,
   output logic                  pc_en,
   output logic [STAGES-1:0]     stage_en,
   output logic [STAGES-1:0]     stage_bubble,
   output logic [STAGES-1:0]     valid,
   output logic [SEL_W-1:0]      fwd_sel_rs,
   output logic [SEL_W-1:0]      fwd_sel_rt,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   logic [STAGES-1:0]     valid_q;
   logic [REG_ADDR_W-1:0] sb_dst [2:STAGES-1];
   logic [STAGES-1:2]     sb_rw;
   logic [STAGES-1:2]     sb_ld;

   logic [STAGES-1:2]     hit_rs;
   logic [STAGES-1:2]     hit_rt;
   logic [STAGES-1:2]     avail;

   logic                  rs_hit, rs_avail;
   logic                  rt_hit, rt_avail;
   logic [SEL_W-1:0]      rs_stage, rt_stage;
   logic                  eff_redirect;
   logic                  hazard;

   for (genvar k = 2; k < STAGES; k++) begin : g_match
      assign hit_rs[k] = valid_q[k] & sb_rw[k] & (sb_dst[k] == id_rs) & (id_rs != '0) & id_use_rs;
      assign hit_rt[k] = valid_q[k] & sb_rw[k] & (sb_dst[k] == id_rt) & (id_rt != '0) & id_use_rt;
      assign avail[k]  = sb_ld[k] ? (k >= LOAD_AVAIL) : (k >= ALU_AVAIL);
   end

   // Scan oldest to youngest so the youngest producer is the one left standing.
   always_comb begin
      rs_hit   = 1'b0;
      rs_avail = 1'b0;
      rs_stage = '0;
      rt_hit   = 1'b0;
      rt_avail = 1'b0;
      rt_stage = '0;
      for (int k = STAGES - 1; k >= 2; k--) begin
         if (hit_rs[k]) begin
            rs_hit   = 1'b1;
            rs_avail = avail[k];
            rs_stage = SEL_W'(k);
         end
         if (hit_rt[k]) begin
            rt_hit   = 1'b1;
            rt_avail = avail[k];
            rt_stage = SEL_W'(k);
         end
      end
   end

   assign eff_redirect = redirect & valid_q[BR_STAGE];
   assign hazard       = valid_q[1] & ((rs_hit & ~rs_avail) | (rt_hit & ~rt_avail)) & ~eff_redirect;

   assign stall      = ~rst & hazard;
   assign fwd_sel_rs = (rst | ~rs_hit | ~rs_avail) ? '0 : rs_stage;
   assign fwd_sel_rt = (rst | ~rt_hit | ~rt_avail) ? '0 : rt_stage;
   assign valid      = valid_q;

   // NOTE: every output gets a default before any branch, so no path infers a latch.
   always_comb begin
      pc_en        = 1'b0;
      stage_en     = '0;
      stage_bubble = '0;
      if (!rst && enable) begin
         pc_en    = 1'b1;
         stage_en = '1;
         if (eff_redirect) begin
            for (int k = 1; k <= BR_STAGE; k++) stage_bubble[k] = 1'b1;
         end else if (hazard) begin
            pc_en           = 1'b0;
            stage_en[1:0]   = 2'b00;
            stage_bubble[2] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         sb_rw     <= '0;
         sb_ld     <= '0;
         // NOTE: the scoreboard is a small register array, cleared with everything else.
         for (int k = 2; k < STAGES; k++) sb_dst[k] <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stage_en[0]) valid_q[0] <= 1'b1;
         for (int k = 1; k < STAGES; k++) begin
            if (stage_en[k]) valid_q[k] <= stage_bubble[k] ? 1'b0 : valid_q[k-1];
         end

         if (stage_en[2]) begin
            sb_dst[2] <= stage_bubble[2] ? '0 : id_dst;
            sb_rw[2]  <= ~stage_bubble[2] & id_reg_write;
            sb_ld[2]  <= ~stage_bubble[2] & id_is_load;
         end
         for (int k = 3; k < STAGES; k++) begin
            if (stage_en[k]) begin
               sb_dst[k] <= stage_bubble[k] ? '0 : sb_dst[k-1];
               sb_rw[k]  <= ~stage_bubble[k] & sb_rw[k-1];
               sb_ld[k]  <= ~stage_bubble[k] & sb_ld[k-1];
            end
         end

         if (enable && hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (enable && eff_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a stage-array reference model.
module tb_pipe_hazard_ctrl;

   localparam int STAGES     = 5;
   localparam int RW         = 5;
   localparam int BR_STAGE   = 2;
   localparam int ALU_AVAIL  = 2;
   localparam int LOAD_AVAIL = 4;
   localparam int SEL_W      = $clog2(STAGES);
   localparam int SAT_MAX    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable, id_use_rs, id_use_rt, id_reg_write, id_is_load, redirect;
   logic [RW-1:0] id_rs, id_rt, id_dst;

   logic              pc_en, stall;
   logic [STAGES-1:0] stage_en, stage_bubble, valid;
   logic [SEL_W-1:0]  fwd_sel_rs, fwd_sel_rt;
   logic [31:0]       stall_cnt, flush_cnt;

   logic              s_pc_en, s_stall;
   logic [STAGES-1:0] s_stage_en, s_stage_bubble, s_valid;
   logic [SEL_W-1:0]  s_fwd_sel_rs, s_fwd_sel_rt;
   logic [1:0]        s_stall_cnt, s_flush_cnt;

   pipe_hazard_ctrl #(.STAGES(STAGES), .REG_ADDR_W(RW), .BR_STAGE(BR_STAGE),
      .ALU_AVAIL(ALU_AVAIL), .LOAD_AVAIL(LOAD_AVAIL), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load), .id_dst(id_dst), .redirect(redirect), .pc_en(pc_en),
      .stage_en(stage_en), .stage_bubble(stage_bubble), .valid(valid),
      .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .stall(stall),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   // Narrow-counter twin sharing all inputs, used to observe saturation.
   pipe_hazard_ctrl #(.STAGES(STAGES), .REG_ADDR_W(RW), .BR_STAGE(BR_STAGE),
      .ALU_AVAIL(ALU_AVAIL), .LOAD_AVAIL(LOAD_AVAIL), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load), .id_dst(id_dst), .redirect(redirect), .pc_en(s_pc_en),
      .stage_en(s_stage_en), .stage_bubble(s_stage_bubble), .valid(s_valid),
      .fwd_sel_rs(s_fwd_sel_rs), .fwd_sel_rt(s_fwd_sel_rt), .stall(s_stall),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   typedef struct {
      logic rst, en;
      logic [RW-1:0] rs, rt;
      logic urs, urt, rw, ld;
      logic [RW-1:0] dst;
      logic redir;
   } in_t;

   typedef struct {
      logic [STAGES-1:0] valid;
      logic stall, pc_en;
      logic [STAGES-1:0] se, bub;
      logic [SEL_W-1:0] frs, frt;
      int scnt, fcnt;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic in_t mk(logic r, logic en, int rs, int rt, logic urs, logic urt,
                              logic rw, logic ld, int dst, logic redir);
      in_t v;
      v.rst = r; v.en = en; v.rs = RW'(rs); v.rt = RW'(rt); v.urs = urs; v.urt = urt;
      v.rw = rw; v.ld = ld; v.dst = RW'(dst); v.redir = redir;
      return v;
   endfunction

   function automatic exp_t mke(logic [STAGES-1:0] vld, logic st, logic pc, logic [STAGES-1:0] se,
                                logic [STAGES-1:0] bub, int frs, int frt, int sc, int fc);
      exp_t e;
      e.valid = vld; e.stall = st; e.pc_en = pc; e.se = se; e.bub = bub;
      e.frs = SEL_W'(frs); e.frt = SEL_W'(frt); e.scnt = sc; e.fcnt = fc;
      return e;
   endfunction

   task automatic add(input in_t i, input exp_t e);
      vec_t v;
      v.i = i; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t v);
      rst = v.rst; enable = v.en; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs;
      id_use_rt = v.urt; id_reg_write = v.rw; id_is_load = v.ld; id_dst = v.dst;
      redirect = v.redir;
   endtask

   task automatic cmp_exp(input string tag, input exp_t e);
      check({tag, ".valid"}, 64'(valid), 64'(e.valid));
      check({tag, ".stall"}, 64'(stall), 64'(e.stall));
      check({tag, ".pc_en"}, 64'(pc_en), 64'(e.pc_en));
      check({tag, ".stage_en"}, 64'(stage_en), 64'(e.se));
      check({tag, ".stage_bubble"}, 64'(stage_bubble), 64'(e.bub));
      check({tag, ".fwd_sel_rs"}, 64'(fwd_sel_rs), 64'(e.frs));
      check({tag, ".fwd_sel_rt"}, 64'(fwd_sel_rt), 64'(e.frt));
      check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(e.scnt));
      check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(e.fcnt));
      check({tag, ".sat_stall_cnt"}, 64'(s_stall_cnt), 64'(e.scnt > SAT_MAX ? SAT_MAX : e.scnt));
      check({tag, ".sat_flush_cnt"}, 64'(s_flush_cnt), 64'(e.fcnt > SAT_MAX ? SAT_MAX : e.fcnt));
   endtask

   // Apply one cycle: inputs after the edge, compare mid-cycle, then take the edge.
   task automatic cycle(input string tag, input in_t i, input exp_t e);
      drive(i);
      @(negedge clk);
      cmp_exp(tag, e);
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model: one record per stage ----------------
   bit          mv[STAGES];
   logic [RW-1:0] md[STAGES];
   bit          mw[STAGES];
   bit          ml[STAGES];
   int          ms, mf;

   function automatic void ref_src(input logic [RW-1:0] s, input logic u, output bit blk, output int sel);
      bit found = 0;
      blk = 0;
      sel = 0;
      for (int k = 2; k < STAGES; k++) begin
         if (!found && u && s != 0 && mv[k] && mw[k] && md[k] == s) begin
            found = 1;
            if (k >= (ml[k] ? LOAD_AVAIL : ALU_AVAIL)) sel = k;
            else blk = 1;
         end
      end
   endfunction

   function automatic exp_t ref_exp(output bit st, output bit rd);
      exp_t e;
      bit b_rs, b_rt;
      int s_rs, s_rt;
      ref_src(id_rs, id_use_rs, b_rs, s_rs);
      ref_src(id_rt, id_use_rt, b_rt, s_rt);
      rd = redirect && mv[BR_STAGE];
      st = mv[1] && (b_rs || b_rt) && !rd;
      for (int k = 0; k < STAGES; k++) e.valid[k] = mv[k];
      e.scnt = ms;
      e.fcnt = mf;
      e.frs = SEL_W'(s_rs);
      e.frt = SEL_W'(s_rt);
      e.stall = st;
      e.pc_en = 0; e.se = '0; e.bub = '0;
      if (rst) begin
         e.stall = 0; e.frs = '0; e.frt = '0;
      end else if (enable) begin
         e.pc_en = 1;
         e.se = '1;
         if (rd) begin
            for (int k = 1; k <= BR_STAGE; k++) e.bub[k] = 1;
         end else if (st) begin
            e.pc_en = 0;
            e.se[0] = 0; e.se[1] = 0;
            e.bub[2] = 1;
         end
      end
      return e;
   endfunction

   task automatic ref_clear();
      for (int k = 0; k < STAGES; k++) begin
         mv[k] = 0; md[k] = '0; mw[k] = 0; ml[k] = 0;
      end
      ms = 0;
      mf = 0;
   endtask

   task automatic ref_edge(input bit st, input bit rd);
      bit nv[STAGES];
      logic [RW-1:0] nd[STAGES];
      bit nw[STAGES];
      bit nl[STAGES];
      if (rst) begin
         ref_clear();
      end else if (enable) begin
         for (int k = 3; k < STAGES; k++) begin
            nv[k] = mv[k-1]; nd[k] = md[k-1]; nw[k] = mw[k-1]; nl[k] = ml[k-1];
         end
         nv[2] = mv[1]; nd[2] = id_dst; nw[2] = id_reg_write; nl[2] = id_is_load;
         nv[1] = mv[0]; nd[1] = '0; nw[1] = 0; nl[1] = 0;
         nv[0] = 1;     nd[0] = '0; nw[0] = 0; nl[0] = 0;
         if (rd) begin
            for (int k = 1; k <= BR_STAGE; k++) begin
               nv[k] = 0; nd[k] = '0; nw[k] = 0; nl[k] = 0;
            end
         end else if (st) begin
            nv[0] = mv[0]; nv[1] = mv[1];
            nv[2] = 0; nd[2] = '0; nw[2] = 0; nl[2] = 0;
         end
         for (int k = 0; k < STAGES; k++) begin
            mv[k] = nv[k]; md[k] = nd[k]; mw[k] = nw[k]; ml[k] = nl[k];
         end
         if (st) ms++;
         if (rd) mf++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      in_t hold;
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;

      // ---------------- directed vector table ----------------
      add(mk(1,1, 0,0,0,0, 0,0,0,0), mke(5'b00000,0,0,5'b00000,5'b00000,0,0,0,0));
      add(mk(0,1, 0,0,0,0, 0,0,0,0), mke(5'b00000,0,1,5'b11111,5'b00000,0,0,0,0));
      add(mk(0,1, 0,0,0,0, 0,0,0,0), mke(5'b00001,0,1,5'b11111,5'b00000,0,0,0,0));
      add(mk(0,1, 0,0,0,0, 0,0,0,0), mke(5'b00011,0,1,5'b11111,5'b00000,0,0,0,0));
      add(mk(0,1, 0,0,0,0, 0,0,0,0), mke(5'b00111,0,1,5'b11111,5'b00000,0,0,0,0));
      add(mk(0,1, 0,0,0,0, 1,0,3,0), mke(5'b01111,0,1,5'b11111,5'b00000,0,0,0,0)); // ALU r3 enters
      add(mk(0,1, 3,0,1,0, 0,0,0,0), mke(5'b11111,0,1,5'b11111,5'b00000,2,0,0,0)); // fwd from EX
      add(mk(0,1, 3,0,1,0, 1,1,5,0), mke(5'b11111,0,1,5'b11111,5'b00000,3,0,0,0)); // load r5 enters
      add(mk(0,1, 0,5,0,1, 0,0,0,0), mke(5'b11111,1,0,5'b11100,5'b00100,0,0,0,0)); // load-use
      add(mk(0,1, 0,5,0,1, 0,0,0,0), mke(5'b11011,1,0,5'b11100,5'b00100,0,0,1,0));
      add(mk(0,1, 0,5,0,1, 0,0,0,0), mke(5'b10011,0,1,5'b11111,5'b00000,0,4,2,0));
      add(mk(0,1, 0,0,0,0, 1,1,6,0), mke(5'b00111,0,1,5'b11111,5'b00000,0,0,2,0)); // load r6 enters
      add(mk(0,1, 6,0,1,0, 0,0,0,1), mke(5'b01111,0,1,5'b11111,5'b00110,0,0,2,0)); // redirect beats stall
      add(mk(0,1, 6,0,1,0, 0,0,0,0), mke(5'b11001,0,1,5'b11111,5'b00000,0,0,2,1)); // ID empty: no stall
      add(mk(0,1, 6,0,1,0, 1,0,0,0), mke(5'b10011,0,1,5'b11111,5'b00000,4,0,2,1)); // last-stage fwd
      add(mk(0,1, 0,0,1,1, 1,0,7,0), mke(5'b00111,0,1,5'b11111,5'b00000,0,0,2,1)); // r0 never matches
      add(mk(0,1, 7,7,0,0, 0,0,0,0), mke(5'b01111,0,1,5'b11111,5'b00000,0,0,2,1)); // unused sources
      add(mk(0,1, 0,7,0,1, 1,1,9,0), mke(5'b11111,0,1,5'b11111,5'b00000,0,3,2,1)); // load r9 enters
      foreach (vecs[n]) cycle($sformatf("vec%0d", n), vecs[n].i, vecs[n].e);

      // ---------------- enable low mid-stall freezes everything ----------------
      hold = mk(0,0, 9,0,1,0, 0,0,0,0);
      for (int c = 0; c < 3; c++)
         cycle($sformatf("freeze%0d", c), hold, mke(5'b11111,1,0,5'b00000,5'b00000,0,0,2,1));
      hold.en = 1;
      cycle("resume0", hold, mke(5'b11111,1,0,5'b11100,5'b00100,0,0,2,1));
      cycle("resume1", hold, mke(5'b11011,1,0,5'b11100,5'b00100,0,0,3,1));
      cycle("resume2", mk(0,1, 9,0,1,0, 1,1,10,0), mke(5'b10011,0,1,5'b11111,5'b00000,4,0,4,1));

      // ---------------- reset asserted mid-stall ----------------
      cycle("rst_pre", mk(0,1, 0,10,0,1, 0,0,0,0), mke(5'b00111,1,0,5'b11100,5'b00100,0,0,4,1));
      cycle("rst_in", mk(1,1, 0,10,0,1, 0,0,0,0), mke(5'b01011,0,0,5'b00000,5'b00000,0,0,5,1));
      drive(mk(1,1, 0,10,0,1, 0,0,0,0));
      cmp_exp("rst_after", mke(5'b00000,0,0,5'b00000,5'b00000,0,0,0,0));

      // ---------------- randomized traffic vs. reference model ----------------
      ref_clear();
      for (int c = 0; c < 800; c++) begin
         exp_t e;
         bit st, rd;
         rst          = ($urandom_range(0, 149) == 0);
         enable       = ($urandom_range(0, 7) != 0);
         id_rs        = RW'($urandom_range(0, 3));
         id_rt        = RW'($urandom_range(0, 3));
         id_use_rs    = 1'($urandom_range(0, 1));
         id_use_rt    = 1'($urandom_range(0, 1));
         id_reg_write = ($urandom_range(0, 3) != 0);
         id_is_load   = ($urandom_range(0, 2) == 0);
         id_dst       = RW'($urandom_range(0, 3));
         redirect     = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         e = ref_exp(st, rd);
         cmp_exp($sformatf("rand%0d", c), e);
         @(posedge clk);
         ref_edge(st, rd);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline-control unit for the in-order MIPS pipeline. It tracks per-stage valid bits and a destination scoreboard for a `STAGES`-deep pipeline. From these it generates:
- per-stage enable and bubble (flush) controls,
- load-use and not-yet-available stalls,
- control-transfer squashing,
- operand forwarding selects for the ID stage,
- saturating stall and flush performance counters.

It sits beside the pipeline registers and drives their enables. It replaces the single global `enable` used so far.

## Interface
Parameters:
- `STAGES`, 5: pipeline depth. Stage 0 = IF, 1 = ID, 2 = EX, and so on; must be ≥ 4.
- `REG_ADDR_W`, 5: register address width.
- `BR_STAGE`, 2: stage in which branches and jumps resolve; range 2..STAGES-1.
- `ALU_AVAIL`, 2: first stage whose result is forwardable for non-load producers; must be ≥ 2.
- `LOAD_AVAIL`, 4: first stage whose result is forwardable for loads; must be ≥ ALU_AVAIL and ≤ STAGES-1.
- `CNT_W`, 32: width of the performance counters.
- Derived: `SEL_W` = $clog2(STAGES).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `enable` in 1: global run. When low, all state holds and all `stage_en` are 0.
- `id_rs`, `id_rt` in REG_ADDR_W: source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1: the instruction in ID actually reads that source.
- `id_reg_write`, `id_is_load` in 1: ID instruction writes a register / is a load.
- `id_dst` in REG_ADDR_W: destination register of the ID instruction (after the reg_dst mux).
- `redirect` in 1: taken branch or jump currently in stage BR_STAGE.
- `pc_en` out 1: PC update enable.
- `stage_en` out STAGES: load enable for the pipeline register feeding stage k.
- `stage_bubble` out STAGES: when 1 together with `stage_en[k]`, stage k loads a bubble (control fields zero).
- `valid` out STAGES: stage k holds a live instruction.
- `fwd_sel_rs`, `fwd_sel_rt` out SEL_W: operand source. 0 = register file; k = forward from stage k.
- `stall` out 1: hazard stall this cycle.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation
Scoreboard
- Stages 2..STAGES-1 each hold {valid, dst, reg_write, is_load}.
- The scoreboard shifts one stage per enabled cycle.
- Stage 2 loads the id_* fields when ID advances. It loads zeros when a bubble is inserted.

Producer match for source s
- Stage k matches when all hold: k ≥ 2, `valid[k]`, `reg_write`, `dst == s`, `s != 0`, and the corresponding `id_use_*` is set.
- The youngest match (lowest k) wins.

Forwarding
- A producer is available if k ≥ (is_load ? LOAD_AVAIL : ALU_AVAIL).
- If the youngest match is available, `fwd_sel` = k. Otherwise `fwd_sel` = 0.
- No match gives `fwd_sel` = 0.

Stall
- `stall` = `valid[1]` & youngest match on rs or rt is unavailable & ~effective redirect.
- During a stall:
  - `pc_en` = 0.
  - `stage_en[0..1]` = 0.
  - `stage_en[2]` = 1 with `stage_bubble[2]` = 1.
  - Older stages advance.

Redirect
- Effective redirect = `redirect & valid[BR_STAGE]`.
- On an effective redirect:
  - `pc_en` = 1 (PC loads the target).
  - `stage_bubble[1..BR_STAGE]` = 1.
  - Stages above BR_STAGE advance normally.
- Redirect has priority over stall.

Normal cycle
- All `stage_en` = 1 and all `stage_bubble` = 0.
- `valid[0]` = 1 after the first enabled cycle following reset.

Counters
- `stall_cnt` increments on each enabled stall cycle.
- `flush_cnt` increments on each effective redirect.
- Both saturate at all-ones.
- Both hold while `enable` is low.

## Timing
- Reset values: all `valid` 0, scoreboard cleared, `stall_cnt` and `flush_cnt` 0.
- During `rst`: `pc_en`, `stage_en`, `stage_bubble` and `stall` are all 0, and `fwd_sel` is 0.
- `stall`, `fwd_sel`, `pc_en`, `stage_en` and `stage_bubble` are combinational from current state and ID inputs, and are valid in the same cycle.
- Valid bits and the scoreboard update on the clock edge where `enable` = 1.
- Load-use with defaults (load in stage 2, consumer in ID): 2 stall cycles, then `fwd_sel` = 4.
- ALU producer in stage 2: no stall; `fwd_sel` = 2 (EX output, same cycle).
- A producer in stage STAGES-1 is still forwarded; the register-file write happens on the same edge.
- `rst` mid-stall or mid-redirect clears everything on the next edge and overrides `enable`.
- `enable` low during a stall freezes the condition; it resumes unchanged when `enable` returns high.

## Test plan
- Reset, then `enable` = 1 for 5 cycles → `valid` = 00001, 00011, 00111, 01111, 11111; `stall` = 0; counters 0.
- ALU dst r3 in stage 2, ID reads rs = r3 → `stall` = 0, `fwd_sel_rs` = 2. Next cycle (producer in stage 3) → `fwd_sel_rs` = 3.
- Load dst r5 in stage 2, ID reads rt = r5 → `stall` = 1 for 2 cycles, then `fwd_sel_rt` = 4 and `stall_cnt` = 2. Each stall cycle inserts a bubble in stage 2.
- `redirect` = 1 with `valid[2]` = 1 while a stall condition is present → `stall` = 0, `stage_bubble[1..2]` = 1, `pc_en` = 1, `flush_cnt` = 1. The next cycle shows `valid[1]` = 0 and `valid[2]` = 0.
- Producer dst r0, or `id_use_rs` = 0 → `fwd_sel` = 0 and no stall. `enable` low for 3 cycles mid-stall → state and counters frozen.
- Preload `stall_cnt` to all-ones minus 1, run 3 stall cycles → the counter holds at all-ones. `rst` asserted mid-stall → all outputs return to reset values on the next edge.
